// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: one bit of x per enabled clock, one-cycle
// match pulse on y, overlapping or non-overlapping matching, saturating match count.
module seq_detector_param #(
    parameter int unsigned LEN     = 4,
    parameter logic [31:0] PATTERN = 32'b1011,
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] cnt
);
    localparam int unsigned    FW  = $clog2(LEN + 1);
    localparam logic [LEN-1:0] PAT = PATTERN[LEN-1:0];

    if (LEN < 2 || LEN > 32) begin : g_len_chk
        $error("seq_detector_param: LEN must be 2..32");
    end
    if ((PATTERN >> LEN) != 32'd0) begin : g_pat_chk
        $error("seq_detector_param: PATTERN wider than LEN");
    end
    if (CNT_W < 1) begin : g_cnt_chk
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    logic [LEN-1:0] hist;
    logic [FW-1:0]  fill;
    logic [LEN-1:0] cand;
    logic [FW-1:0]  cand_fill;
    logic           hit;

    // fill gates matching so reset/clear zeros in hist never count as received bits
    always_comb begin
        cand      = {hist[LEN-2:0], x};
        cand_fill = (fill == FW'(LEN)) ? FW'(LEN) : fill + FW'(1);
        hit       = en & ~clr & (cand_fill == FW'(LEN)) & (cand == PAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
            cnt  <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
            cnt  <= '0;
        end else if (en) begin
            hist <= cand;
            y    <= hit;
            // non-overlap mode keeps shifting hist but demands LEN fresh bits
            fill <= (hit && !OVERLAP) ? '0 : cand_fill;
            if (hit && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end else begin
            y <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five parameter sets share one input stream and are
// compared against a bit-queue reference model, a vector table and directed sequences.
module tb_seq_detector_param;
    localparam int NC = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic x   = 1'b0;

    logic       y0, y1, y2, y3, y4;
    logic [7:0] c0, c1, c3, c4;
    logic [1:0] c2;

    always #5 clk = ~clk;

    seq_detector_param #(.LEN(4), .PATTERN(32'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov
        (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y0), .cnt(c0));
    seq_detector_param #(.LEN(4), .PATTERN(32'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no
        (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y1), .cnt(c1));
    seq_detector_param #(.LEN(4), .PATTERN(32'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat
        (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y2), .cnt(c2));
    seq_detector_param #(.LEN(4), .PATTERN(32'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_zero
        (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y3), .cnt(c3));
    seq_detector_param #(.LEN(6), .PATTERN(32'b110110), .OVERLAP(1'b0), .CNT_W(8)) u_l6
        (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y4), .cnt(c4));

    logic       ya [NC];
    logic [7:0] ca [NC];
    assign ya[0] = y0; assign ca[0] = c0;
    assign ya[1] = y1; assign ca[1] = c1;
    assign ya[2] = y2; assign ca[2] = {6'd0, c2};
    assign ya[3] = y3; assign ca[3] = c3;
    assign ya[4] = y4; assign ca[4] = c4;

    // reference model: accepted bits since the last reset/clear/(non-overlap) match
    int lens [NC] = '{4, 4, 4, 4, 6};
    int pats [NC] = '{'b1011, 'b1011, 'b1111, 'b0000, 'b110110};
    bit ovs  [NC] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int cmax [NC] = '{255, 255, 3, 255, 255};
    bit mq   [NC][$];
    bit my   [NC];
    int mcnt [NC];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            mq[i].delete();
            my[i]   = 1'b0;
            mcnt[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit c, input bit xb);
        for (int i = 0; i < NC; i++) begin
            if (c) begin
                mq[i].delete();
                my[i]   = 1'b0;
                mcnt[i] = 0;
            end else if (e) begin
                bit hit;
                int v;
                mq[i].push_back(xb);
                if (mq[i].size() > lens[i]) void'(mq[i].pop_front());
                hit = 1'b0;
                if (mq[i].size() == lens[i]) begin
                    v = 0;
                    for (int k = 0; k < lens[i]; k++) v = (v << 1) | int'(mq[i][k]);
                    hit = (v == pats[i]);
                end
                my[i] = hit;
                if (hit && !ovs[i]) mq[i].delete();
                if (hit && mcnt[i] < cmax[i]) mcnt[i]++;
            end else begin
                my[i] = 1'b0;
            end
        end
    endtask

    task automatic cmp_model();
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("model_u%0d_y", i), int'(ya[i]), int'(my[i]));
            chk($sformatf("model_u%0d_cnt", i), int'(ca[i]), mcnt[i]);
        end
    endtask

    // drive, clock once, then compare well after the edge
    task automatic step(input bit e, input bit c, input bit xb);
        en = e; clr = c; x = xb;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_edge(e, c, xb);
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        cmp_model();
        rst = 1'b1;
    endtask

    typedef struct {
        bit e, c, xb;
        bit y_ov; int cnt_ov;
        bit y_no; int cnt_no;
    } vec_t;
    vec_t vt[13];

    initial begin
        int pulses;

        vt[0]  = '{1, 0, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 0, 1, 1, 1, 1, 1};
        vt[4]  = '{1, 0, 0, 0, 1, 0, 1};
        vt[5]  = '{1, 0, 1, 0, 1, 0, 1};
        vt[6]  = '{1, 0, 1, 1, 2, 0, 1};
        vt[7]  = '{1, 0, 1, 0, 2, 0, 1};
        vt[8]  = '{1, 0, 0, 0, 2, 0, 1};
        vt[9]  = '{1, 0, 1, 0, 2, 0, 1};
        vt[10] = '{1, 0, 1, 1, 3, 1, 2};
        vt[11] = '{0, 0, 1, 0, 3, 0, 2};
        vt[12] = '{0, 0, 0, 0, 3, 0, 2};

        // reset state, then overlap / non-overlap vector table
        do_reset();
        chk("reset_y", int'(y0), 0);
        chk("reset_cnt", int'(c0), 0);
        for (int k = 0; k < 13; k++) begin
            step(vt[k].e, vt[k].c, vt[k].xb);
            chk($sformatf("tbl%0d_ov_y", k), int'(y0), int'(vt[k].y_ov));
            chk($sformatf("tbl%0d_ov_cnt", k), int'(c0), vt[k].cnt_ov);
            chk($sformatf("tbl%0d_no_y", k), int'(y1), int'(vt[k].y_no));
            chk($sformatf("tbl%0d_no_cnt", k), int'(c1), vt[k].cnt_no);
        end

        // asynchronous reset: outputs clear between edges
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("pre_async_y", int'(y0), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_y", int'(y0), 0);
        chk("async_cnt", int'(c0), 0);
        chk("async_cnt_no", int'(c1), 0);
        // held in reset with activity on x
        for (int k = 0; k < 6; k++) step(1, 0, k[0]);
        chk("hold_cnt", int'(c0), 0);

        // reset mid-pattern discards the partial 1,0,1
        rst = 1'b1;
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        rst = 1'b0;
        step(1, 0, 0);
        rst = 1'b1;
        step(1, 0, 1);
        chk("midreset_no_pulse", int'(y0), 0);

        // enable gaps with garbage on x
        do_reset();
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            step(1, 0, bits[b]);
            if (y0) pulses++;
            if (b == 3) chk("gap_pulse", int'(y0), 1);
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 1'($urandom_range(0, 1)));
                chk("gap_y_low", int'(y0), 0);
            end
        end
        chk("gap_pulse_count", pulses, 1);

        // saturation on CNT_W=2, then clear and refill
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 1);
            chk($sformatf("sat%0d_y", k), int'(y2), (k >= 4) ? 1 : 0);
            chk($sformatf("sat%0d_cnt", k), int'(c2), (k <= 3) ? 0 : ((k - 3 > 3) ? 3 : k - 3));
        end
        step(1, 1, 1);
        chk("clr_y", int'(y2), 0);
        chk("clr_cnt", int'(c2), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 1);
            chk($sformatf("refill%0d_y", k), int'(y2), (k == 4) ? 1 : 0);
        end

        // all-zero pattern needs LEN real zeros
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0);
            chk($sformatf("zero%0d_y", k), int'(y3), (k == 4) ? 1 : 0);
        end

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: samples one bit of `x` per `clk` rising edge and pulses `y` for one cycle whenever the last `LEN` accepted bits equal `PATTERN`. Overlapping or non-overlapping matching is selected by parameter. A saturating match counter is included. This is the generic successor to the team's fixed-pattern single-output sequence detectors and drops into the same serial-input slot (`x` in, `y` out, `clk`, `rst`).

## Interface
- `LEN`, 4: pattern length in bits; legal range 2..32.
- `PATTERN`, 4'b1011: target sequence, `LEN` bits wide; MSB is the first bit received, LSB the last.
- `OVERLAP`, 1: 1 = a match's bits may start the next match; 0 = history is discarded after each match.
- `CNT_W`, 8: width of the match counter.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `en` input 1: bit-accept strobe; `x` is consumed only on edges where `en`=1.
- `clr` input 1: synchronous clear of history, fill, `y`, `cnt`; has priority over `en`.
- `x` input 1: serial data bit.
- `y` output 1: registered one-cycle match pulse.
- `cnt` output CNT_W: number of matches since reset/clear, saturating at all-ones.

## Operation
- State:
  - `hist[LEN-1:0]`: newest bit in LSB.
  - `fill`: 0..LEN, counts accepted bits, saturating at LEN.
  - `y` register.
  - `cnt` register.
- Combinational per edge:
  - `cand = {hist[LEN-2:0], x}`.
  - `cand_fill = min(fill+1, LEN)`.
  - `hit = en & ~clr & (cand_fill == LEN) & (cand == PATTERN)`.
- Rising edge, priority order:
  - `clr`=1: `hist`<=0, `fill`<=0, `y`<=0, `cnt`<=0.
  - Else if `en`=1:
    - `hist`<=`cand`.
    - `y`<=`hit`.
    - `fill`<=0 if `hit` and `OVERLAP`=0, else `cand_fill`.
    - If `hit` and `cnt` != all-ones: `cnt`<=`cnt`+1.
  - Else (`en`=0): `hist`, `fill`, `cnt` hold; `y`<=0.
- `fill` gating: no match may fire until `LEN` bits have been accepted since reset, clear, or (non-overlap mode) the previous match. Reset zeros in `hist` never form a match.
- Non-overlap mode: `hist` still shifts on a hit, but `fill`=0 forces `LEN` fresh bits before the next match.
- `cnt` saturates: once at 2^CNT_W-1, further hits still pulse `y` but `cnt` holds.
- Parameters outside the legal range, or a `PATTERN` wider than `LEN`, are an elaboration error.

## Timing
- Reset: `rst`=0 immediately (asynchronously) forces `hist`=0, `fill`=0, `y`=0, `cnt`=0, independent of `clk`. Deassertion takes effect from the first rising edge with `rst`=1. Reset mid-sequence discards all partial history.
- Latency: the bit completing a pattern is sampled on edge N. `y`=1 and the incremented `cnt` are visible after edge N and held until edge N+1.
- `y` is never high for two consecutive cycles unless consecutive accepted bits each complete a match. That is possible only with `OVERLAP`=1 and a periodic `PATTERN` (e.g. all-ones).
- `en` gaps are transparent: bits accepted across idle cycles form a sequence exactly as if contiguous.
- `x`, `en` and `clr` must be stable around the rising edge. No combinational path exists from any input to any output.

## Test plan
- Reset: hold `rst`=0 with `x` toggling and `en`=1 -> `y`=0, `cnt`=0 throughout. Drop `rst` mid-pattern (after bits 1,0,1), release, feed 1 -> no pulse.
- Overlap (LEN=4, PATTERN=1011, OVERLAP=1): `en`=1, x = 1,0,1,1,0,1,1 -> `y` pulses after the 4th and 7th bits; `cnt`=2.
- Non-overlap (same, OVERLAP=0): x = 1,0,1,1,0,1,1 -> pulse only after the 4th bit. Then feed 1,0,1,1 -> pulse after the 11th bit; `cnt`=2.
- Enable gaps: x = 1,0,1,1 with `en`=0 for 3 cycles between each bit (x driven to garbage while `en`=0) -> exactly one pulse, one cycle after the 4th accepted bit. `y`=0 during gaps.
- Clear and saturation (CNT_W=2, PATTERN=1111, OVERLAP=1): ten consecutive 1s -> `y` high from the 4th bit onward for 7 cycles; `cnt` stops at 3. Assert `clr` with `en`=1, x=1 -> next cycle `y`=0, `cnt`=0; four more 1s are needed before the next pulse.
- Start-up fill guard (PATTERN=0000): after reset feed x = 0,0,0 -> no pulse; the 4th 0 -> pulse.
